// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation through a single 1-bit slice, LSB first,
// one bit per clock, with overflow/zero/slt resolved on the MSB cycle.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted on any rising edge where start=1 and busy=0
  // (IDLE or the DONE cycle); start while busy=1 is dropped, nothing is queued.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-2:0] sr;

  logic             accept, last, binv, is_slt, is_arith_ov;
  logic             bit_a, bit_b, sum, cout, slice_out;
  logic [WIDTH-1:0] res_shift, final_res;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;
  assign accept    = start && (state != RUN);
  assign last      = (cnt == CW'(WIDTH - 1));

  assign binv        = (op_q == 3'b110) || (op_q == 3'b111);
  assign is_slt      = (op_q == 3'b111);
  assign is_arith_ov = (op_q == 3'b010) || (op_q == 3'b110);

  // The 1-bit ALU slice
  always_comb begin
    bit_a = a_q[cnt];
    bit_b = b_q[cnt] ^ binv;
    sum   = bit_a ^ bit_b ^ carry;
    cout  = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
    case (op_q)
      3'b000:  slice_out = bit_a & bit_b;
      3'b001:  slice_out = bit_a | bit_b;
      3'b011:  slice_out = ~(bit_a & bit_b);
      3'b100:  slice_out = ~(bit_a | bit_b);
      default: slice_out = sum;
    endcase
  end

  // New bit enters at the MSB side; after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = {slice_out, sr};
  assign final_res = is_slt ? {{(WIDTH-1){1'b0}}, slice_out} : res_shift;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    next_state = accept ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sr       <= '0;
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= op;
      cnt   <= '0;
      carry <= (op == 3'b110) || (op == 3'b111);
    end else if (state == RUN) begin
      sr    <= res_shift[WIDTH-1:1];
      carry <= cout;
      cnt   <= cnt + CW'(1);
      if (last) begin
        result   <= final_res;
        // slt reports the raw sign bit, so its overflow stays 0
        overflow <= is_arith_ov && (carry ^ cout);
        zero     <= (final_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq at WIDTH=8: timing, per-op results, flags,
// ignored/back-to-back starts and mid-run reset.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, overflow, zero;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .zero(zero), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; starts the op there (edge 0) and returns at the negedge of cycle 9.
  // With poke=1 a second start with a=0x11 is pulsed in cycle 4 and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic eov,
                        input logic ez, input logic poke);
    logic timing_ok;
    timing_ok = 1'b1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= W; i++) begin
      start = poke && (i == 4);
      a     = (poke && (i == 4)) ? 8'h11 : ~x;
      b     = ~y;
      op    = 3'b000;
      if (busy !== 1'b1 || done !== 1'b0) timing_ok = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_run"}, 32'(timing_ok), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_overflow"}, 32'(overflow), 32'(eov));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  task automatic idle(input string tag, input logic [W-1:0] er);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic saw_done;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("add_7f_01", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
    idle("add_7f_01", 8'h80);
    run_op("sub_05_05", 3'b110, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
    idle("sub_05_05", 8'h00);
    run_op("and_cc_aa", 3'b000, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0);
    run_op("or_cc_aa",  3'b001, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("slt_03_07", 3'b111, 8'h03, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("slt_07_03", 3'b111, 8'h07, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("slt_ff_01", 3'b111, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("nor_f0_0f", 3'b100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("nand_ff_0f", 3'b011, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("op101_01_01", 3'b101, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    idle("op101_01_01", 8'h02);

    // Ignored mid-run start, then a start issued in the DONE cycle
    run_op("add_poke", 3'b010, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1);
    run_op("b2b_sub_30_10", 3'b110, 8'h30, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    idle("b2b_sub_30_10", 8'h20);

    run_op("sub_80_01", 3'b110, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0);
    idle("sub_80_01", 8'h7F);

    // Reset asserted in cycle 4 of a run
    op = 3'b010; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    run_op("add_01_02", 3'b010, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    idle("add_01_02", 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
